// File: rtl/serial_addsub_param.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples DIGIT bits per clock, LSB first.
// Define SERIAL_ADDSUB_MAGNITUDE_EN to add a FIX cycle that returns |a-b| with a neg flag.
module serial_addsub_param #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             neg
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
`else
    typedef enum logic [0:0] {IDLE, CALC} state_t;
`endif

    // Handshake: start is accepted on a rising edge only while busy=0; done pulses
    // for one cycle with result/cout/ovf/neg valid, and those hold until the next done.
    state_t state, state_next;

    logic [WIDTH-1:0]       a_sh, b_sh, res_sh;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic [DIGIT:0]         slice;
    logic [DIGIT-1:0]       sum_d;
    logic                   c_out, c_msb, ovf_d, last, go_fix;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
    logic m_q, ovf_q;
    assign go_fix = m_q & ~c_out;
`else
    assign go_fix = 1'b0;
`endif

    assign slice    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign sum_d    = slice[DIGIT-1:0];
    assign c_out    = slice[DIGIT];
    // Carry into the top bit of the slice, recovered from that bit's sum equation.
    assign c_msb    = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ sum_d[DIGIT-1];
    assign ovf_d    = c_msb ^ c_out;
    assign res_cat  = {sum_d, res_sh};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last     = (cnt == CW'(NDIG - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                if (last) begin
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
                    state_next = go_fix ? FIX : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
            FIX:  state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            neg    <= 1'b0;
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
            m_q    <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{m}};
                        carry <= m ? 1'b1 : cin;
                        cnt   <= '0;
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
                        m_q   <= m;
`endif
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= c_out;
                    res_sh <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last && !go_fix) begin
                        result <= res_next;
                        cout   <= c_out;
                        ovf    <= ovf_d;
                        neg    <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
                    if (last) ovf_q <= ovf_d;
`endif
                end
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
                // carry/ovf_q still hold the raw subtraction flags here.
                FIX: begin
                    result <= ~res_sh + WIDTH'(1);
                    cout   <= carry;
                    ovf    <= ovf_q;
                    neg    <= 1'b1;
                    done   <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_param.sv
// Bench for serial_addsub_param: DIGIT=4, 1 and 16 instances share stimulus and are
// scored against a reference model through per-instance expected queues.
module tb_serial_addsub_param;
    localparam int W = 16;
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
    localparam bit MAG = 1'b1;
`else
    localparam bit MAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, m, cin;
    logic [W-1:0] a, b;
    logic busy4, done4, cout4, ovf4, neg4;
    logic busy1, done1, cout1, ovf1, neg1;
    logic busy16, done16, cout16, ovf16, neg16;
    logic [W-1:0] result4, result1, result16;

    int checks = 0;
    int errors = 0;
    int rem[3];
    logic [18:0] exp_q4[$];
    logic [18:0] exp_q1[$];
    logic [18:0] exp_q16[$];

    always #5 clk = ~clk;

    serial_addsub_param #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .m(m), .a(a), .b(b), .cin(cin),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4), .neg(neg4));
    serial_addsub_param #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .m(m), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1), .neg(neg1));
    serial_addsub_param #(.WIDTH(W), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .m(m), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16), .neg(neg16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {result[15:0], cout, ovf, neg}.
    function automatic logic [18:0] model(input logic mm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                          input logic cc);
        logic [W:0]   s;
        logic [W-1:0] bx, r;
        logic         co, ov, ng;
        bx = mm ? ~bb : bb;
        s  = {1'b0, aa} + {1'b0, bx} + {{W{1'b0}}, (mm ? 1'b1 : cc)};
        r  = s[W-1:0];
        co = s[W];
        ov = (aa[W-1] == bx[W-1]) && (r[W-1] != aa[W-1]);
        ng = 1'b0;
        if (MAG && mm && !co) begin
            r  = bb - aa;
            ng = 1'b1;
        end
        return {r, co, ov, ng};
    endfunction

    function automatic int lat(input int dig, input logic [18:0] e, input logic mm);
        return W / dig + ((MAG && mm && !e[2]) ? 1 : 0);
    endfunction

    // Reference busy/accept model: pushes expectations on every start a given instance accepts.
    always @(posedge clk) begin
        logic [18:0] e;
        if (rst) begin
            rem = '{0, 0, 0};
            exp_q4.delete();
            exp_q1.delete();
            exp_q16.delete();
        end else begin
            e = model(m, a, b, cin);
            if (start && rem[0] == 0) begin exp_q4.push_back(e);  rem[0] = lat(4, e, m);  end
            else if (rem[0] > 0) rem[0]--;
            if (start && rem[1] == 0) begin exp_q1.push_back(e);  rem[1] = lat(1, e, m);  end
            else if (rem[1] > 0) rem[1]--;
            if (start && rem[2] == 0) begin exp_q16.push_back(e); rem[2] = lat(16, e, m); end
            else if (rem[2] > 0) rem[2]--;
        end
    end

    task automatic cmp_out(input string pfx, input logic [18:0] e, input logic [W-1:0] r,
                           input logic co, input logic ov, input logic ng);
        chk({pfx, "_result"}, r, e[18:3]);
        chk({pfx, "_cout"}, co, e[2]);
        chk({pfx, "_ovf"}, ov, e[1]);
        chk({pfx, "_neg"}, ng, e[0]);
    endtask

    always @(negedge clk) if (done4) begin
        chk("d4_done_expected", exp_q4.size() != 0, 1);
        if (exp_q4.size() != 0) cmp_out("d4", exp_q4.pop_front(), result4, cout4, ovf4, neg4);
    end
    always @(negedge clk) if (done1) begin
        chk("d1_done_expected", exp_q1.size() != 0, 1);
        if (exp_q1.size() != 0) cmp_out("d1", exp_q1.pop_front(), result1, cout1, ovf1, neg1);
    end
    always @(negedge clk) if (done16) begin
        chk("d16_done_expected", exp_q16.size() != 0, 1);
        if (exp_q16.size() != 0) cmp_out("d16", exp_q16.pop_front(), result16, cout16, ovf16, neg16);
    end

    task automatic scramble();
        m   = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        a   = 16'($urandom_range(0, 65535));
        b   = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_within_bound", k < 60, 1);
        @(negedge clk); #1;
    endtask

    task automatic wait_done4(output int k);
        k = 0;
        while (done4 !== 1'b1 && k < 40) begin
            chk("busy4_during_op", busy4, 1);
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic run_op(input logic mm, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
        logic [18:0] e;
        int k;
        e = model(mm, aa, bb, cc);
        @(negedge clk);
        m = mm; a = aa; b = bb; cin = cc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        wait_done4(k);
        chk("lat4", k, lat(4, e, mm));
        chk("busy4_low_at_done", busy4, 0);
        @(posedge clk); #1;
        chk("done4_one_cycle", done4, 0);
        chk("result4_held", result4, e[18:3]);
        wait_idle();
    endtask

    initial begin
        logic [18:0] ea;
        int k;
        rst = 1'b1; start = 1'b0; m = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_result4", result4, 0);
        chk("rst_flags4", {cout4, ovf4, neg4}, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy16", busy16, 0);
        rst = 1'b0;

        run_op(1'b0, 16'h1234, 16'h0FFF, 1'b1);
        run_op(1'b1, 16'h0005, 16'h0003, 1'b1);
        run_op(1'b1, 16'h0003, 16'h0005, 1'b0);
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

        // Start raised again while busy must not disturb the running operation.
        ea = model(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        m = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_idle();
        chk("busy_start_ignored", result4, ea[18:3]);

        // Back-to-back: new start during the done cycle.
        @(negedge clk);
        m = 1'b0; a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done4(k);
        chk("b2b_first_lat", k, 4);
        m = 1'b1; a = 16'h4000; b = 16'h0123; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        scramble();
        wait_done4(k);
        chk("b2b_second_lat", k, 4);
        wait_idle();

        // Reset in the middle of an operation.
        @(negedge clk);
        m = 1'b0; a = 16'hABCD; b = 16'h1357; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy4", busy4, 0);
        chk("midrst_done4", done4, 0);
        chk("midrst_result4", result4, 0);
        chk("midrst_flags4", {cout4, ovf4, neg4}, 0);
        chk("midrst_busy1", busy1, 0);
        chk("midrst_result16", result16, 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_done4", done4, 0);
        end
        run_op(1'b0, 16'h1234, 16'h0FFF, 1'b1);

        chk("q4_drained", exp_q4.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);
        chk("q16_drained", exp_q16.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_addsub_param.md
Name: serial_addsub_param

Overview:
- Parametrised multi-cycle adder/subtractor. Generalises the 4-bit combinational ripple add/sub to WIDTH bits.
- Processes DIGIT bits per clock, LSB-first, through a DIGIT-bit ripple slice, trading latency for area.
- Start/done handshake. Carry, signed-overflow and optional sign-magnitude outputs.
- Used wherever wide add/sub is needed without a full-width carry chain.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
- NDIG (localparam) = WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- m  input  1  mode: 0 = add (a+b+cin), 1 = subtract (a-b; cin ignored).
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in for add; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  sum/difference; held until the next completion.
- cout  output  1  add: carry out. Subtract: 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- neg  output  1  magnitude-mode negative flag (see Optional Feature); 0 otherwise.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; busy, done, result, cout, ovf, neg all 0; internal shift registers and counter cleared. Reset mid-operation aborts it; no done is produced.
- States: IDLE, CALC, FIX (FIX exists only with the macro).
- IDLE + start=1 at edge T:
  - capture a, b^{WIDTH{m}}, m;
  - carry register = m ? 1 : cin;
  - digit counter = 0; go to CALC; busy=1 from T.
- CALC, each edge:
  - add the low DIGIT bits of A and B' plus the carry register;
  - shift the DIGIT sum bits into the result shift register from the MSB side;
  - shift A and B' right by DIGIT; update carry; increment counter.
  - On the final digit (counter = NDIG-1), also record carry-into-MSB for ovf.
- Completion (no macro): at edge T+NDIG:
  - result, cout, ovf registered; done=1 for exactly one cycle; busy=0; state to IDLE.
  - Latency from accepted start to done = NDIG cycles.
- start while busy=1 is ignored; no queuing.
- start=1 in the done cycle is accepted (busy=0 then), giving back-to-back operations every NDIG cycles.
- Inputs a, b, cin, m may change freely after the start edge without effect.
- DIGIT=WIDTH degenerates to a single-cycle registered add/sub (NDIG=1).
- Carry/borrow wrap-around is modular: result is always the low WIDTH bits.

Optional Feature:
- Macro: SERIAL_ADDSUB_MAGNITUDE_EN.
- Defined:
  - after CALC, if m=1 and cout=0 (a < b unsigned), go to FIX for one cycle;
  - FIX sets result = ~result + 1 (magnitude b-a) and neg=1; done follows at T+NDIG+1.
  - Otherwise (add, or a >= b) done at T+NDIG with neg=0.
  - cout and ovf report the raw operation unchanged.
- Undefined: no FIX state; result is raw two's complement; neg tied 0; latency always NDIG.

Test Plan (WIDTH=16, DIGIT=4):
1. m=0, a=0x1234, b=0x0FFF, cin=1 -> result=0x2234, cout=0, ovf=0; done exactly 4 cycles after start edge, busy high in between.
2. m=1, a=0x0005, b=0x0003, cin=1 (ignored) -> result=0x0002, cout=1, ovf=0, neg=0.
3. m=1, a=0x0003, b=0x0005:
   - no macro -> result=0xFFFE, cout=0, neg=0, done at 4 cycles;
   - with macro -> result=0x0002, neg=1, done at 5 cycles.
4. Overflow and carry cases, m=0, cin=0:
   - a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1, cout=0;
   - a=0xFFFF, b=0x0001 -> result=0x0000, cout=1, ovf=0.
5. Handshake:
   - start re-asserted at cycle 2 of an operation -> ignored; the original result is unchanged;
   - new start in the done cycle -> accepted, next done 4 cycles later.
6. Reset and variants:
   - rst=1 at cycle 2 of an operation -> all outputs 0 next cycle, no done; a new op then completes normally;
   - repeat tests 1-4 with DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency) -> same results.
